// File: rtl/axi4_lite_slave_responder_pkg.sv
// Shared state constants, response encodings and the address-decode result type
// for the AXI4-Lite slave responder.
package Axi4LiteGlobalsPkg;

  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_DELAY  = 2'd1;
  localparam logic [1:0] WR_ACCEPT = 2'd2;
  localparam logic [1:0] WR_RESP   = 2'd3;

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_DELAY  = 2'd1;
  localparam logic [1:0] RD_ACCEPT = 2'd2;
  localparam logic [1:0] RD_RESP   = 2'd3;

  typedef enum logic [1:0] {
    WRITE_OKAY   = 2'b00,
    WRITE_EXOKAY = 2'b01,
    WRITE_SLVERR = 2'b10,
    WRITE_DECERR = 2'b11
  } brespEnum;

  typedef enum logic [1:0] {
    READ_OKAY   = 2'b00,
    READ_EXOKAY = 2'b01,
    READ_SLVERR = 2'b10,
    READ_DECERR = 2'b11
  } rrespEnum;

  // Index field is sized for the largest supported register file.
  localparam int MAX_INDEX_W = 8;

  typedef struct packed {
    logic [MAX_INDEX_W-1:0] index;
    logic                   decErr;
    logic                   slvErr;
  } addr_decode_t;

endpackage

// File: rtl/axi4_lite_slave_responder_if.sv
// AXI4-Lite bus bundle between a master and the slave responder.
interface axi4_lite_slave_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_responder_delay.sv
// Loadable down-counter pacing ready assertion; done flags the final wait cycle,
// clear drops a pending count when the master withdraws its request.
module axi4_lite_ready_delay_counter #(
  parameter int DELAY_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DELAY_WIDTH-1:0] load_value,
  input  logic                   clear,
  input  logic                   dec,
  output logic                   done
);
  logic [DELAY_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == DELAY_WIDTH'(1));
endmodule

// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite slave: byte-strobed register file behind independent write/read FSMs with ready delay.
// Define AXI4_LITE_SLAVE_PROT_CHECK_EN to reject non-secure accesses to the upper register half.
module axi4_lite_slave_responder
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DELAY_WIDTH   = 5,
  parameter int                       NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DELAY_WIDTH-1:0] writeReadyDelay,
  input  logic [DELAY_WIDTH-1:0] readReadyDelay,
  axi4_lite_slave_responder_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  // The decoded window is a power of two, so any set bit above it is out of range,
  // including addresses below BASE_ADDR that wrap to a large offset.
  function automatic addr_decode_t decode(input logic [ADDRESS_WIDTH-1:0] addr,
                                          input logic                     nonsecure);
    logic [ADDRESS_WIDTH-1:0] offset;
    addr_decode_t             d;
    offset   = addr - BASE_ADDR;
    d.index  = MAX_INDEX_W'(offset[BYTE_W +: IDX_W]);
    d.decErr = |offset[ADDRESS_WIDTH-1:BYTE_W+IDX_W];
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    d.slvErr = !d.decErr && nonsecure && offset[BYTE_W+IDX_W-1];
`else
    d.slvErr = 1'b0 & nonsecure;
`endif
    return d;
  endfunction

  logic [1:0]            wr_state, wr_next;
  logic [1:0]            rd_state, rd_next;
  logic                  wr_load, wr_clear, wr_dec, wr_done;
  logic                  rd_load, rd_clear, rd_dec, rd_done;
  logic                  wr_req;
  addr_decode_t          wr_decode, rd_decode;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign wr_req    = bus.awvalid && bus.wvalid;
  assign wr_decode = decode(bus.awaddr, bus.awprot[1]);
  assign rd_decode = decode(bus.araddr, bus.arprot[1]);
  assign wr_idx    = wr_decode.index[IDX_W-1:0];
  assign rd_idx    = rd_decode.index[IDX_W-1:0];

  axi4_lite_ready_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_wr_delay (
    .clk(aclk), .rst_n(aresetn), .load(wr_load), .load_value(writeReadyDelay),
    .clear(wr_clear), .dec(wr_dec), .done(wr_done)
  );

  axi4_lite_ready_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_rd_delay (
    .clk(aclk), .rst_n(aresetn), .load(rd_load), .load_value(readReadyDelay),
    .clear(rd_clear), .dec(rd_dec), .done(rd_done)
  );

  // Write channel: address and data must both be presented before the delay starts.
  always_comb begin
    wr_next  = wr_state;
    wr_load  = 1'b0;
    wr_clear = 1'b0;
    wr_dec   = 1'b0;
    case (wr_state)
      WR_IDLE: if (wr_req) begin
        wr_load = 1'b1;
        wr_next = (writeReadyDelay == '0) ? WR_ACCEPT : WR_DELAY;
      end
      WR_DELAY: begin
        if (!wr_req) begin
          wr_clear = 1'b1;
          wr_next  = WR_IDLE;
        end else if (wr_done) begin
          wr_next = WR_ACCEPT;
        end else begin
          wr_dec = 1'b1;
        end
      end
      WR_ACCEPT: wr_next = WR_RESP;
      WR_RESP:   if (bus.bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next  = rd_state;
    rd_load  = 1'b0;
    rd_clear = 1'b0;
    rd_dec   = 1'b0;
    case (rd_state)
      RD_IDLE: if (bus.arvalid) begin
        rd_load = 1'b1;
        rd_next = (readReadyDelay == '0) ? RD_ACCEPT : RD_DELAY;
      end
      RD_DELAY: begin
        if (!bus.arvalid) begin
          rd_clear = 1'b1;
          rd_next  = RD_IDLE;
        end else if (rd_done) begin
          rd_next = RD_ACCEPT;
        end else begin
          rd_dec = 1'b1;
        end
      end
      RD_ACCEPT: rd_next = RD_RESP;
      RD_RESP:   if (bus.rready) rd_next = RD_IDLE;
      default:   rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Register file update and write response capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bresp_q <= WRITE_OKAY;
    end else if (wr_state == WR_ACCEPT) begin
      if (wr_decode.decErr) begin
        bresp_q <= WRITE_DECERR;
      end else if (wr_decode.slvErr) begin
        bresp_q <= WRITE_SLVERR;
      end else begin
        bresp_q <= WRITE_OKAY;
        for (int b = 0; b < STRB_W; b++) begin
          if (bus.wstrb[b]) regs[wr_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before a coincident write lands, returning the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= READ_OKAY;
    end else if (rd_state == RD_ACCEPT) begin
      if (rd_decode.decErr) begin
        rdata_q <= '0;
        rresp_q <= READ_DECERR;
      end else if (rd_decode.slvErr) begin
        rdata_q <= '0;
        rresp_q <= READ_SLVERR;
      end else begin
        rdata_q <= regs[rd_idx];
        rresp_q <= READ_OKAY;
      end
    end
  end

  assign bus.awready = (wr_state == WR_ACCEPT);
  assign bus.wready  = (wr_state == WR_ACCEPT);
  assign bus.bvalid  = (wr_state == WR_RESP);
  assign bus.bresp   = bresp_q;
  assign bus.arready = (rd_state == RD_ACCEPT);
  assign bus.rvalid  = (rd_state == RD_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_slave_responder.sv
// Self-checking bench for axi4_lite_slave_responder: vector table, corner sequences,
// and random traffic against a register-file reference model.
`timescale 1ns/1ps
module tb_axi4_lite_slave_responder;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DLW   = 5;
  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [DLW-1:0] writeReadyDelay = '0;
  logic [DLW-1:0] readReadyDelay = '0;

  axi4_lite_slave_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW), .NUM_REGS(NREGS), .BASE_ADDR(BASE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .writeReadyDelay(writeReadyDelay),
    .readReadyDelay(readReadyDelay), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain array of words addressed by byte offset from BASE.
  logic [31:0] mregs [NREGS];

  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] prot);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= NREGS * 4) return 2'b11;
    if (PROT_EN && prot[1] && (off / 4) >= NREGS / 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot);
    int idx;
    idx = int'((addr - BASE) / 4);
    if (model_resp(addr, prot) == 2'b00)
      for (int b = 0; b < 4; b++) if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] prot);
    if (model_resp(addr, prot) != 2'b00) return 32'h0;
    return mregs[int'((addr - BASE) / 4)];
  endfunction

  // Cycle counts are relative to the cycle in which the valids are first driven.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [2:0] prot, input int dly,
                    output logic [1:0] resp, output int t_rdy, output int t_b);
    int k;
    writeReadyDelay = DLW'(dly);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.awprot = prot;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!bus.awready && k < 64) begin @(negedge aclk); k++; end
    t_rdy = k;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; k++;
    @(negedge aclk);
    while (!bus.bvalid && k < 128) begin @(negedge aclk); k++; end
    t_b = k; resp = bus.bresp;
    @(posedge aclk); #1;
    if (k >= 128) begin n_cmp++; n_err++; $display("FAIL wr_timeout: got no bvalid, expected bvalid"); end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] prot, input int dly,
                    output logic [31:0] data, output logic [1:0] resp,
                    output int t_rdy, output int t_r);
    int k;
    readReadyDelay = DLW'(dly);
    bus.araddr = addr; bus.arprot = prot; bus.arvalid = 1'b1; bus.rready = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!bus.arready && k < 64) begin @(negedge aclk); k++; end
    t_rdy = k;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0; k++;
    @(negedge aclk);
    while (!bus.rvalid && k < 128) begin @(negedge aclk); k++; end
    t_r = k; data = bus.rdata; resp = bus.rresp;
    @(posedge aclk); #1;
    if (k >= 128) begin n_cmp++; n_err++; $display("FAIL rd_timeout: got no rvalid, expected rvalid"); end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] data, data2;
    int          t1, t2, t3, t4, t;
    bit          bad;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;

    vecs.push_back('{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 0, 2'b00, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h08, 32'h11223344, 4'h2, 3'b000, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 2, 2'b00, 32'h00003300});
    vecs.push_back('{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b000, 1, 2'b11, 32'h0});
    vecs.push_back('{1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 0, 2'b11, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, 32'h3C, 32'hA5A5A5A5, 4'h9, 3'b000, 3, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h3F, 32'h0, 4'h0, 3'b000, 1, 2'b00, 32'hA50000A5});
    vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 3'b000, 0, 2'b11, 32'h0});
    vecs.push_back('{1'b0, 32'hFFFFFFF0, 32'h0, 4'h0, 3'b000, 0, 2'b11, 32'h0});
    vecs.push_back('{1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 3'b010, 0, PROT_EN ? 2'b10 : 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 3'b010, 0, PROT_EN ? 2'b10 : 2'b00,
                     PROT_EN ? 32'h0 : 32'h5A5A5A5A});
    vecs.push_back('{1'b1, 32'h20, 32'h0BADCAFE, 4'hF, 3'b000, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 0, 2'b00, 32'h0BADCAFE});
    vecs.push_back('{1'b1, 32'h04, 32'h00000000, 4'h0, 3'b000, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 0, 2'b00, 32'hDEADBEEF});

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    check("reset_outputs",
          {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp, bus.rdata},
          '0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // Vector table
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot, vecs[i].dly, resp, t1, t2);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_wready_cycle", i), t1, vecs[i].dly + 1);
        check($sformatf("vec%0d_bvalid_cycle", i), t2, vecs[i].dly + 2);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot);
      end else begin
        rd(vecs[i].addr, vecs[i].prot, vecs[i].dly, data, resp, t1, t2);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
        check($sformatf("vec%0d_arready_cycle", i), t1, vecs[i].dly + 1);
        check($sformatf("vec%0d_rvalid_cycle", i), t2, vecs[i].dly + 2);
      end
    end

    // Staggered valids with delay 3: the count starts only once both are high.
    writeReadyDelay = 5'd3;
    bus.awaddr = 32'h10; bus.wdata = 32'h11223344; bus.wstrb = 4'h2; bus.awprot = 3'b000;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b1;
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge aclk);
      if (bus.awready) t = k;
      else begin @(posedge aclk); #1; if (k + 1 == 2) bus.wvalid = 1'b1; end
    end
    check("stagger_ready_cycle", t, 6);
    check("stagger_wready", bus.wready, 1'b1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    t = 0;
    @(negedge aclk);
    while (!bus.bvalid && t < 20) begin @(negedge aclk); t++; end
    check("stagger_bresp", {bus.bvalid, bus.bresp}, 3'b100);
    @(posedge aclk); #1;
    model_write(32'h10, 32'h11223344, 4'h2, 3'b000);
    rd(32'h10, 3'b000, 0, data, resp, t1, t2);
    check("stagger_rdata", data, 32'h00003300);

    // Simultaneous accept on one register: the read sees the old contents.
    wr(32'h14, 32'h11111111, 4'hF, 3'b000, 0, resp, t1, t2);
    model_write(32'h14, 32'h11111111, 4'hF, 3'b000);
    fork
      wr(32'h14, 32'h22222222, 4'hF, 3'b000, 0, resp, t1, t2);
      rd(32'h14, 3'b000, 0, data, resp2, t3, t4);
    join
    check("same_cycle_accept", t1, t3);
    check("same_cycle_rdata", data, 32'h11111111);
    model_write(32'h14, 32'h22222222, 4'hF, 3'b000);
    rd(32'h14, 3'b000, 0, data, resp, t1, t2);
    check("after_same_cycle_rdata", data, 32'h22222222);

    // bready stall: response held, new request not accepted.
    writeReadyDelay = 5'd0;
    bus.awaddr = 32'h40; bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.awprot = 3'b000;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    t = 0;
    @(negedge aclk);
    while (!bus.awready && t < 20) begin @(negedge aclk); t++; end
    @(posedge aclk); #1;
    bus.awaddr = 32'h0C; bus.wdata = 32'h77777777;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("stall_cycle%0d_bvalid_bresp_awready", i), {bus.bvalid, bus.bresp, bus.awready}, 4'b1110);
    end
    @(posedge aclk); #1;
    bus.bready = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!bus.awready && t < 20) begin @(negedge aclk); t++; end
    check("stall_release_accept_cycle", t, 2);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    t = 0;
    @(negedge aclk);
    while (!bus.bvalid && t < 20) begin @(negedge aclk); t++; end
    check("stall_second_bresp", {bus.bvalid, bus.bresp}, 3'b100);
    @(posedge aclk); #1;
    model_write(32'h0C, 32'h77777777, 4'hF, 3'b000);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [2:0]  p;
      int          dl;
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = BASE + 32'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(0, 3));
      d = $urandom(); s = 4'($urandom_range(0, 15)); p = 3'($urandom_range(0, 7));
      dl = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wr(a, d, s, p, dl, resp, t1, t2);
        check($sformatf("rand%0d_bresp@%0h", n, a), resp, model_resp(a, p));
        check($sformatf("rand%0d_bvalid_cycle", n), t2, dl + 2);
        model_write(a, d, s, p);
      end else begin
        rd(a, p, dl, data, resp, t1, t2);
        check($sformatf("rand%0d_rresp@%0h", n, a), resp, model_resp(a, p));
        check($sformatf("rand%0d_rdata@%0h", n, a), data, model_read(a, p));
        check($sformatf("rand%0d_arready_cycle", n), t1, dl + 1);
      end
    end

    // Asynchronous reset in the middle of a delayed write.
    writeReadyDelay = 5'd10;
    bus.awaddr = 32'h04; bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.awprot = 3'b000;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    repeat (3) @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp, bus.rdata},
          '0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      if (bus.bvalid || bus.awready) bad = 1'b1;
    end
    check("no_response_after_reset", bad, 1'b0);
    @(posedge aclk); #1;
    rd(32'h04, 3'b000, 0, data, resp, t1, t2);
    check("reg4_after_reset", {resp, data}, {2'b00, 32'h0});
    rd(32'h3C, 3'b000, 0, data, resp, t1, t2);
    check("reg15_after_reset", data, model_read(32'h3C, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
